// File: rtl/bbox_overlay.sv
// ============================================================================
// Module   : bbox_overlay
// Function : Red-object bounding-box detector and overlay on a DVI-style
//            pixel stream. Hits from frame N are accumulated into a box that
//            is drawn as a 1-pixel border during frame N+1. 2-cycle latency.
// Options  : BBOX_MASK_EN - paint non-border hit pixels white (24'hFFFFFF).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bbox_overlay #(
  parameter logic [7:0]  R_MIN     = 8'd160,
  parameter logic [7:0]  GB_MAX    = 8'd96,
  parameter logic [23:0] BOX_COLOR = 24'h00FF00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_de,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic [7:0] in_red,
  input  logic [7:0] in_green,
  input  logic [7:0] in_blue,
  output logic       out_de,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic [7:0] out_red,
  output logic [7:0] out_green,
  output logic [7:0] out_blue
);

  localparam logic [10:0] COORD_MAX = 11'd2047;

  // Stage-1 pipeline: delayed controls, pixel and the pixel's coordinates
  logic        de1, hs1, vs1;
  logic [23:0] pix1;
  logic [10:0] x1, y1;

  // Running counters (x holds the column of the last active pixel)
  logic [10:0] x_cnt, y_cnt;

  // Frame accumulators and the latched box from the previous frame
  logic [10:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic        acc_any;
  logic [10:0] box_xmin, box_xmax, box_ymin, box_ymax;
  logic        box_valid;
  // Set by the first vsync edge after reset; the frame that edge closes is
  // only partial, so its box must not be shown.
  logic        armed;

  logic        vs_rise, de_fall, hit;
  logic [10:0] cur_x, cur_y;
  logic [10:0] nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;
  logic        nxt_any;
  logic        on_col, on_row, border;
  logic [23:0] pix2;

  // de1/vs1 double as the previous-cycle values for edge detection
  assign vs_rise = in_vsync & ~vs1;
  assign de_fall = ~in_de & de1;
  assign cur_x   = !de1 ? 11'd0 : (x_cnt == COORD_MAX) ? COORD_MAX : x_cnt + 11'd1;
  // A pixel on the vsync edge cycle already belongs to row 0 of the new frame
  assign cur_y   = vs_rise ? 11'd0 : y_cnt;
  assign hit     = in_de && (in_red >= R_MIN) && (in_green < GB_MAX) && (in_blue < GB_MAX);

  // Next accumulator values: restart on the vsync edge, then fold in this hit
  always_comb begin
    nxt_xmin = vs_rise ? COORD_MAX : acc_xmin;
    nxt_xmax = vs_rise ? 11'd0     : acc_xmax;
    nxt_ymin = vs_rise ? COORD_MAX : acc_ymin;
    nxt_ymax = vs_rise ? 11'd0     : acc_ymax;
    nxt_any  = vs_rise ? 1'b0      : acc_any;
    if (hit) begin
      if (cur_x < nxt_xmin) nxt_xmin = cur_x;
      if (cur_x > nxt_xmax) nxt_xmax = cur_x;
      if (cur_y < nxt_ymin) nxt_ymin = cur_y;
      if (cur_y > nxt_ymax) nxt_ymax = cur_y;
      nxt_any = 1'b1;
    end
  end

  // Column/row counters with saturation; vsync edge restarts the rows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= 11'd0;
      y_cnt <= 11'd0;
    end else begin
      if (in_de) x_cnt <= cur_x;
      if (vs_rise) y_cnt <= 11'd0;
      else if (de_fall && (y_cnt != COORD_MAX)) y_cnt <= y_cnt + 11'd1;
    end
  end

  // Accumulate hits; on the vsync edge hand the finished frame's box over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_xmin  <= COORD_MAX;
      acc_xmax  <= 11'd0;
      acc_ymin  <= COORD_MAX;
      acc_ymax  <= 11'd0;
      acc_any   <= 1'b0;
      box_xmin  <= 11'd0;
      box_xmax  <= 11'd0;
      box_ymin  <= 11'd0;
      box_ymax  <= 11'd0;
      box_valid <= 1'b0;
      armed     <= 1'b0;
    end else begin
      acc_xmin <= nxt_xmin;
      acc_xmax <= nxt_xmax;
      acc_ymin <= nxt_ymin;
      acc_ymax <= nxt_ymax;
      acc_any  <= nxt_any;
      if (vs_rise) begin
        box_xmin  <= acc_xmin;
        box_xmax  <= acc_xmax;
        box_ymin  <= acc_ymin;
        box_ymax  <= acc_ymax;
        box_valid <= acc_any & armed;
        armed     <= 1'b1;
      end
    end
  end

  // Stage 1: register controls, pixel and its coordinates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de1  <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      pix1 <= 24'd0;
      x1   <= 11'd0;
      y1   <= 11'd0;
    end else begin
      de1  <= in_de;
      hs1  <= in_hsync;
      vs1  <= in_vsync;
      pix1 <= {in_red, in_green, in_blue};
      x1   <= cur_x;
      y1   <= cur_y;
    end
  end

  assign on_col = ((x1 == box_xmin) || (x1 == box_xmax)) && (y1 >= box_ymin) && (y1 <= box_ymax);
  assign on_row = ((y1 == box_ymin) || (y1 == box_ymax)) && (x1 >= box_xmin) && (x1 <= box_xmax);
  assign border = de1 && box_valid && (on_col || on_row);

`ifdef BBOX_MASK_EN
  logic hit1;

  // Carry the hit flag alongside the stage-1 pixel for masking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit1 <= 1'b0;
    else     hit1 <= hit;
  end

  assign pix2 = border ? BOX_COLOR : (hit1 ? 24'hFFFFFF : pix1);
`else
  assign pix2 = border ? BOX_COLOR : pix1;
`endif

  // Stage 2: registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_de    <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_red   <= 8'd0;
      out_green <= 8'd0;
      out_blue  <= 8'd0;
    end else begin
      out_de    <= de1;
      out_hsync <= hs1;
      out_vsync <= vs1;
      {out_red, out_green, out_blue} <= pix2;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bbox_overlay.sv
// ============================================================================
// Module   : tb_bbox_overlay
// Function : Self-checking bench for bbox_overlay using 64x48 frames and a
//            queue of expected output words produced by a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bbox_overlay;

  localparam int HACT = 64;
  localparam int VACT = 48;
  localparam int HTOT = 72;
  localparam int VBL  = 3;
  localparam int FRAME_CYC = (VACT + VBL) * HTOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_de = 1'b0, in_hsync = 1'b0, in_vsync = 1'b0;
  logic [7:0] in_red = 8'd0, in_green = 8'd0, in_blue = 8'd0;
  logic       out_de, out_hsync, out_vsync;
  logic [7:0] out_red, out_green, out_blue;

  bbox_overlay dut (
    .clk(clk), .rst(rst),
    .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync),
    .out_red(out_red), .out_green(out_green), .out_blue(out_blue)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [26:0] val;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   tick = 0;
  int   paint_cnt = 0;
  int   mask_cnt = 0;

  // Reference model state
  bit m_prev_vs, m_armed, m_valid, m_any;
  int ax0, ax1, ay0, ay1, bx0, bx1, by0, by1;

  function automatic logic [23:0] pix_of(int pat, int x, int y);
    logic [23:0] p;
    p = {8'(x), 8'(y * 4), 8'(x ^ y)};   // ramp, red never reaches 160
    case (pat)
      1: if (x >= 20 && x <= 29 && y >= 8 && y <= 13) p = 24'hC80000;
      2: if (x == 63 && y == 47) p = 24'hC80000;
      3: begin
        if (x == 5 && y == 5)   p = 24'hA05F5F;   // (160,95,95) hit
        if (x == 40 && y == 30) p = 24'h9F0000;   // (159,0,0) no hit
        if (x == 50 && y == 40) p = 24'hC86000;   // (200,96,0) no hit
      end
      default: ;
    endcase
    return p;
  endfunction

  task automatic model_reset();
    m_prev_vs = 0; m_armed = 0; m_valid = 0; m_any = 0;
    ax0 = 2047; ax1 = 0; ay0 = 2047; ay1 = 0;
    bx0 = 0; bx1 = 0; by0 = 0; by1 = 0;
  endtask

  // One clock: check the output due now against the queue, then drive the
  // next input word and push its expected output.
  task automatic drive_cycle(input bit de, input bit hs, input bit vs,
                             input logic [23:0] pix, input int px, input int py);
    exp_t e;
    bit   hit, border;
    logic [23:0] epix;
    @(negedge clk);
    if (q.size() > 0 && q[0].tag == tick - 2) begin
      e = q.pop_front();
      compared++;
      if ({out_de, out_hsync, out_vsync, out_red, out_green, out_blue} !== e.val) begin
        mismatched++;
        $display("FAIL pix tick=%0d got %h expected %h", tick,
                 {out_de, out_hsync, out_vsync, out_red, out_green, out_blue}, e.val);
      end
      if (out_de && {out_red, out_green, out_blue} == 24'h00FF00) paint_cnt++;
      if (out_de && {out_red, out_green, out_blue} == 24'hFFFFFF) mask_cnt++;
    end
    in_de = de; in_hsync = hs; in_vsync = vs;
    {in_red, in_green, in_blue} = pix;

    hit = de && pix[23:16] >= 8'd160 && pix[15:8] < 8'd96 && pix[7:0] < 8'd96;
    if (vs && !m_prev_vs) begin
      bx0 = ax0; bx1 = ax1; by0 = ay0; by1 = ay1;
      m_valid = m_any && m_armed;
      m_armed = 1;
      ax0 = 2047; ax1 = 0; ay0 = 2047; ay1 = 0; m_any = 0;
    end
    m_prev_vs = vs;
    if (hit) begin
      if (px < ax0) ax0 = px;
      if (px > ax1) ax1 = px;
      if (py < ay0) ay0 = py;
      if (py > ay1) ay1 = py;
      m_any = 1;
    end
    border = de && m_valid &&
             (((px == bx0 || px == bx1) && py >= by0 && py <= by1) ||
              ((py == by0 || py == by1) && px >= bx0 && px <= bx1));
    epix = border ? 24'h00FF00 : pix;
`ifdef BBOX_MASK_EN
    if (!border && hit) epix = 24'hFFFFFF;
`endif
    e.tag = tick;
    e.val = {de, hs, vs, epix};
    q.push_back(e);
    tick++;
  endtask

  task automatic drive_line(input int pat, input int ly, input int npix);
    for (int c = 0; c < npix; c++) begin
      drive_cycle(c < HACT, c >= 66 && c < 70, 1'b0,
                  (c < HACT) ? pix_of(pat, c, ly) : 24'd0, c, ly);
    end
  endtask

  task automatic drive_vblank();
    for (int l = 0; l < VBL; l++)
      for (int c = 0; c < HTOT; c++)
        drive_cycle(1'b0, c >= 66 && c < 70, l == 0, 24'd0, c, 0);
  endtask

  task automatic run_frame(input int pat);
    drive_vblank();
    for (int ly = 0; ly < VACT; ly++) drive_line(pat, ly, HTOT);
  endtask

  task automatic test_reset();
    int p0;
    model_reset();
    repeat (2) @(negedge clk);
    compared++;
    if ({out_de, out_hsync, out_vsync, out_red, out_green, out_blue} !== 27'd0) begin
      mismatched++;
      $display("FAIL rst_init got %h expected 0",
               {out_de, out_hsync, out_vsync, out_red, out_green, out_blue});
    end
    rst = 1'b0;
    // Partial frame, reset asserted in the middle of line 10
    drive_vblank();
    for (int ly = 0; ly < 10; ly++) drive_line(1, ly, HTOT);
    drive_line(1, 10, 30);
    @(negedge clk);
    in_de = 0; in_hsync = 0; in_vsync = 0;
    {in_red, in_green, in_blue} = 24'd0;
    rst = 1'b1;
    #1;
    compared++;
    if ({out_de, out_hsync, out_vsync, out_red, out_green, out_blue} !== 27'd0) begin
      mismatched++;
      $display("FAIL rst_mid got %h expected 0",
               {out_de, out_hsync, out_vsync, out_red, out_green, out_blue});
    end
    q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    // Rest of the frame still carries hits; none of it may be drawn
    p0 = paint_cnt;
    for (int ly = 11; ly < VACT; ly++) drive_line(1, ly, HTOT);
    compared++;
    if (paint_cnt - p0 !== 0) begin
      mismatched++;
      $display("FAIL rst_partial_paint got %0d expected 0", paint_cnt - p0);
    end
    p0 = paint_cnt;
    run_frame(0);
    compared++;
    if (paint_cnt - p0 !== 0) begin
      mismatched++;
      $display("FAIL rst_next_paint got %0d expected 0", paint_cnt - p0);
    end
  endtask

  task automatic test_latency();
    int c0;
    c0 = compared;
    run_frame(0);
    compared++;
    if (compared - 1 - c0 !== FRAME_CYC) begin
      mismatched++;
      $display("FAIL latency_count got %0d expected %0d", compared - 1 - c0, FRAME_CYC);
    end
  endtask

  task automatic test_box();
    int p0;
    p0 = paint_cnt;
    run_frame(1);
    compared++;
    if (paint_cnt - p0 !== 0) begin
      mismatched++;
      $display("FAIL box_detect_paint got %0d expected 0", paint_cnt - p0);
    end
    p0 = paint_cnt;
    run_frame(0);
    compared++;
    if (paint_cnt - p0 !== 28) begin
      mismatched++;
      $display("FAIL box_border_paint got %0d expected 28", paint_cnt - p0);
    end
  endtask

  task automatic test_single_empty();
    int p0;
    run_frame(2);
    p0 = paint_cnt;
    run_frame(0);
    compared++;
    if (paint_cnt - p0 !== 1) begin
      mismatched++;
      $display("FAIL single_paint got %0d expected 1", paint_cnt - p0);
    end
    p0 = paint_cnt;
    run_frame(0);
    compared++;
    if (paint_cnt - p0 !== 0) begin
      mismatched++;
      $display("FAIL empty_paint got %0d expected 0", paint_cnt - p0);
    end
  endtask

  task automatic test_threshold();
    int p0;
    run_frame(3);
    p0 = paint_cnt;
    run_frame(0);
    compared++;
    if (paint_cnt - p0 !== 1) begin
      mismatched++;
      $display("FAIL threshold_paint got %0d expected 1", paint_cnt - p0);
    end
  endtask

  task automatic test_mask();
    int p0, k0, exp_first, exp_second;
`ifdef BBOX_MASK_EN
    exp_first = 60; exp_second = 32;
`else
    exp_first = 0;  exp_second = 0;
`endif
    k0 = mask_cnt;
    run_frame(1);
    compared++;
    if (mask_cnt - k0 !== exp_first) begin
      mismatched++;
      $display("FAIL mask_nobox got %0d expected %0d", mask_cnt - k0, exp_first);
    end
    k0 = mask_cnt;
    p0 = paint_cnt;
    run_frame(1);
    compared++;
    if (mask_cnt - k0 !== exp_second) begin
      mismatched++;
      $display("FAIL mask_interior got %0d expected %0d", mask_cnt - k0, exp_second);
    end
    compared++;
    if (paint_cnt - p0 !== 28) begin
      mismatched++;
      $display("FAIL mask_border_paint got %0d expected 28", paint_cnt - p0);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_box();
    test_single_empty();
    test_threshold();
    test_mask();
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 24'd0, 0, 0);
    compared++;
    if (q.size() > 2) begin
      mismatched++;
      $display("FAIL drain got %0d pending expected at most 2", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
